// File: rtl/mdu_issue_queue.sv
// Issue queue in front of the multiply/divide unit: buffers decoded MDU ops and
// issues the head op only while the MDU is idle. mfhi/mflo results come back tagged.
module mdu_issue_queue #(
    parameter int unsigned      DEPTH   = 2,
    parameter int unsigned      TYPEW   = 5,
    parameter logic [TYPEW-1:0] OP_MFHI = TYPEW'(7),
    parameter logic [TYPEW-1:0] OP_MFLO = TYPEW'(8)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TYPEW-1:0] in_type,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [4:0]       in_tag,
    input  logic             flush,
    input  logic             mdu_busy,
    input  logic [31:0]      mdu_o,
    output logic [TYPEW-1:0] MDUType,
    output logic [31:0]      A,
    output logic [31:0]      B,
    output logic             res_valid,
    output logic [4:0]       res_tag,
    output logic [31:0]      res_data,
    output logic [15:0]      stall_cnt
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE  = (PW+1)'(1);

    logic [TYPEW-1:0] type_mem [DEPTH];
    logic [31:0]      a_mem    [DEPTH];
    logic [31:0]      b_mem    [DEPTH];
    logic [4:0]       tag_mem  [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    logic             push;
    logic             issue;
    logic [TYPEW-1:0] head_type;
    logic             head_mf;

    assign in_ready  = (count != FULL);
    assign push      = in_valid && in_ready && !flush;
    assign issue     = (count != '0) && !mdu_busy && !flush;
    assign head_type = type_mem[rd_ptr];
    assign head_mf   = (head_type == OP_MFHI) || (head_type == OP_MFLO);

    always_comb begin
        MDUType = '0;
        A       = '0;
        B       = '0;
        if (issue) begin
            MDUType = head_type;
            A       = a_mem[rd_ptr];
            B       = b_mem[rd_ptr];
        end
    end

    // Payload storage needs no reset: it is only read when count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            type_mem[wr_ptr] <= in_type;
            a_mem[wr_ptr]    <= in_a;
            b_mem[wr_ptr]    <= in_b;
            tag_mem[wr_ptr]  <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !issue) begin
                count <= count + ONE;
            end else if (!push && issue) begin
                count <= count - ONE;
            end
        end
    end

    // mdu_o is sampled in the issue cycle, so an mf* sees hi/lo as left by earlier ops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid <= 1'b0;
            res_tag   <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= issue && head_mf;
            if (issue && head_mf) begin
                res_tag  <= tag_mem[rd_ptr];
                res_data <= mdu_o;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if ((count != '0) && mdu_busy && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mdu_issue_queue.sv
// Scoreboarded bench for mdu_issue_queue: the bench plays the MDU by driving busy and mdu_o.
module tb_mdu_issue_queue;

    localparam logic [4:0] MULT  = 5'd1;
    localparam logic [4:0] MULTU = 5'd2;
    localparam logic [4:0] DIV   = 5'd3;
    localparam logic [4:0] DIVU  = 5'd4;
    localparam logic [4:0] MTHI  = 5'd5;
    localparam logic [4:0] MFHI  = 5'd7;
    localparam logic [4:0] MFLO  = 5'd8;
    localparam logic [4:0] BOGUS = 5'd31;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_type;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        flush;
    logic        mdu_busy;
    logic [31:0] mdu_o;
    logic [4:0]  MDUType;
    logic [31:0] A;
    logic [31:0] B;
    logic        res_valid;
    logic [4:0]  res_tag;
    logic [31:0] res_data;
    logic [15:0] stall_cnt;

    mdu_issue_queue #(
        .DEPTH   (2),
        .TYPEW   (5),
        .OP_MFHI (MFHI),
        .OP_MFLO (MFLO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .flush     (flush),
        .mdu_busy  (mdu_busy),
        .mdu_o     (mdu_o),
        .MDUType   (MDUType),
        .A         (A),
        .B         (B),
        .res_valid (res_valid),
        .res_tag   (res_tag),
        .res_data  (res_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  t;
        logic [31:0] a;
        logic [31:0] b;
    } iss_t;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] d;
    } res_t;

    iss_t iss_q[$];
    res_t res_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever the DUT issues or returns a result.
    always @(negedge clk) begin
        if (reset) begin
            if (MDUType != 5'd0) begin
                if (iss_q.size() == 0) begin
                    check("unexpected_issue", {MDUType, A, B}, 69'd0);
                end else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    check("issue", {MDUType, A, B}, e);
                end
            end
            if (res_valid) begin
                if (res_q.size() == 0) begin
                    check("unexpected_result", {res_tag, res_data}, 37'd0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("result", {res_tag, res_data}, r);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [4:0] t, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input logic [31:0] exp_d,
                           input bit issues, input bit nb);
        int n;
        in_valid = 1'b1;
        in_type  = t;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        if (nb) begin
            #1;
            check("no_bypass", MDUType, 5'd0);
        end
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) check("push_ready_timeout", in_ready, 1'b1);
        if (issues) begin
            iss_q.push_back('{t: t, a: a, b: b});
            if (t == MFHI || t == MFLO) res_q.push_back('{tag: tag, d: exp_d});
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        mdu_busy = 1'b0;
        mdu_o    = 32'd0;
        reset    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        in_type = '0;
        in_a    = '0;
        in_b    = '0;
        in_tag  = '0;
        do_reset();

        // 1: async reset with two ops queued behind a busy MDU
        mdu_busy = 1'b1;
        push_op(MULT, 32'd1, 32'd2, 5'd0, 32'd0, 1'b0, 1'b0);
        push_op(DIV,  32'd3, 32'd4, 5'd0, 32'd0, 1'b0, 1'b0);
        #2;
        reset    = 1'b0;
        mdu_busy = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_mdutype", MDUType, 5'd0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_stall_cnt", stall_cnt, 16'd0);
        do_reset();

        // 2: mult 3 * -4 then mflo, blocked by five busy cycles
        push_op(MULT, 32'd3, 32'hFFFFFFFC, 5'd0, 32'd0, 1'b1, 1'b1);
        push_op(MFLO, 32'd0, 32'd0, 5'd8, 32'hFFFFFFF4, 1'b1, 1'b0);
        mdu_busy = 1'b1;
        repeat (5) step();
        mdu_busy = 1'b0;
        mdu_o    = 32'hFFFFFFF4;
        check("t2_stall_cnt", stall_cnt, 16'd5);
        repeat (3) step();
        do_reset();

        // 3: fill the 2-entry queue while busy, third push waits for space
        mdu_busy = 1'b1;
        push_op(MULTU, 32'h11, 32'h22, 5'd0, 32'd0, 1'b1, 1'b0);
        push_op(DIVU,  32'h33, 32'h44, 5'd0, 32'd0, 1'b1, 1'b0);
        check("t3_full", in_ready, 1'b0);
        mdu_busy = 1'b0;
        push_op(DIV,   32'h55, 32'h66, 5'd0, 32'd0, 1'b1, 1'b0);
        step();
        mdu_busy = 1'b1;
        repeat (3) step();
        check("t3_drained_stall", stall_cnt, 16'd1);
        mdu_busy = 1'b0;
        do_reset();

        // 4: simultaneous push/pop with pointer wrap, including an unknown op code
        push_op(MULT,  32'd1, 32'd2, 5'd0, 32'd0, 1'b1, 1'b1);
        push_op(DIV,   32'd3, 32'd4, 5'd0, 32'd0, 1'b1, 1'b0);
        push_op(MULTU, 32'd5, 32'd6, 5'd0, 32'd0, 1'b1, 1'b0);
        push_op(BOGUS, 32'd7, 32'd8, 5'd9, 32'd0, 1'b1, 1'b0);
        mdu_busy = 1'b1;
        step();
        mdu_busy = 1'b0;
        step();
        check("t4_empty_mdutype", MDUType, 5'd0);
        mdu_busy = 1'b1;
        repeat (2) step();
        check("t4_stall_cnt", stall_cnt, 16'd1);
        mdu_busy = 1'b0;
        do_reset();

        // 5: flush two queued ops while a mult is in flight; mfhi then reads its hi
        push_op(MULT, 32'h00010000, 32'h00010000, 5'd0, 32'd0, 1'b1, 1'b0);
        step();
        mdu_busy = 1'b1;
        push_op(MTHI, 32'hDEAD, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        push_op(DIVU, 32'd9, 32'd3, 5'd0, 32'd0, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_flush_mdutype", MDUType, 5'd0);
        check("t5_flush_ready", in_ready, 1'b1);
        check("t5_flush_stall", stall_cnt, 16'd1);
        push_op(MFHI, 32'd0, 32'd0, 5'd5, 32'h1, 1'b1, 1'b0);
        repeat (2) step();
        mdu_busy = 1'b0;
        mdu_o    = 32'h1;
        check("t5_stall_cnt", stall_cnt, 16'd3);
        repeat (3) step();
        do_reset();

        // 6: mthi then mfhi, result two cycles after mthi issue
        mdu_o = 32'h1234;
        push_op(MTHI, 32'h1234, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);
        push_op(MFHI, 32'd0, 32'd0, 5'd3, 32'h1234, 1'b1, 1'b0);
        check("t6_early", res_valid, 1'b0);
        step();
        check("t6_valid", res_valid, 1'b1);
        check("t6_tag", res_tag, 5'd3);
        check("t6_data", res_data, 32'h1234);
        step();
        check("t6_pulse_end", res_valid, 1'b0);
        repeat (3) step();

        check("iss_q_drained", iss_q.size(), 0);
        check("res_q_drained", res_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
